// File: rtl/seq_pkg.sv
// Shared types and helpers for the vector sequencer and its hold timer.
package seq_pkg;

  typedef enum logic [1:0] {IDLE, APPLY, DONE} seq_state_t;

  // Hold-counter width; never narrower than one bit, even for a single-cycle hold.
  function automatic int unsigned hold_width(input int unsigned hold_cycles);
    return (hold_cycles > 2) ? $clog2(hold_cycles) : 1;
  endfunction

endpackage

// File: rtl/vector_sequencer_hold_timer.sv
// Up-counter that times how long each vector is held; tc flags the sample cycle.
module hold_timer
  import seq_pkg::*;
#(
  parameter int unsigned HoldCycles = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int unsigned Width = hold_width(HoldCycles);
  localparam logic [Width-1:0] Last = Width'(HoldCycles - 1);
  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + One;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == Last);

endmodule

// File: rtl/vector_sequencer.sv
// Exhaustive stimulus stage: walks every input vector, samples the unit under
// test on the last hold cycle, and accumulates a mismatch summary.
module vector_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned              N_IN        = 3,
  parameter int unsigned              HOLD_CYCLES = 10,
  parameter logic [(1 << N_IN) - 1:0] EXPECTED    = 8'h31
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            y,
  output logic [N_IN-1:0] vec,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid
);

  localparam logic [N_IN-1:0] VecMax = '1;
  localparam logic [N_IN-1:0] VecOne = N_IN'(1);
  localparam logic [N_IN:0]   ErrOne = (N_IN + 1)'(1);

  seq_state_t      state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] ffv_q, ffv_d;
  logic            ffvalid_q, ffvalid_d;

  logic tc;
  logic mismatch;

  // Counter restarts for every new vector and idles at zero outside APPLY.
  hold_timer #(
    .HoldCycles(HOLD_CYCLES)
  ) u_hold_timer (
    .clk  (clk),
    .reset(reset),
    .clear((state_q != APPLY) || tc),
    .en   (state_q == APPLY),
    .tc   (tc)
  );

  // An X/Z on y must count as a failure in simulation.
`ifdef SYNTHESIS
  assign mismatch = (y != EXPECTED[vec_q]);
`else
  assign mismatch = (y !== EXPECTED[vec_q]);
`endif

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    err_d     = err_q;
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;
    unique case (state_q)
      IDLE: begin
        vec_d = '0;
        if (start) begin
          state_d   = APPLY;
          busy_d    = 1'b1;
          err_d     = '0;
          pass_d    = 1'b0;
          ffv_d     = '0;
          ffvalid_d = 1'b0;
        end
      end
      APPLY: begin
        if (tc) begin
          if (mismatch) begin
            err_d = err_q + ErrOne;
            if (!ffvalid_q) begin
              ffv_d     = vec_q;
              ffvalid_d = 1'b1;
            end
          end
          if (vec_q != VecMax) begin
            vec_d = vec_q + VecOne;
          end else begin
            state_d = DONE;
            vec_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      vec_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
    end
  end

  assign vec              = vec_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench: golden, stuck and single-fault units, ignored starts, mid-run
// reset, and a single-cycle-hold instance.
module tb_vector_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start0, start1;
  logic       y0, y1;
  logic [2:0] vec0, vec1;
  logic       busy0, busy1, done0, done1, pass0, pass1;
  logic [3:0] err0, err1;
  logic [2:0] ffv0, ffv1;
  logic       ffvalid0, ffvalid1;
  int         mode;
  int         total_cnt = 0;
  int         bad_cnt = 0;

  always #5 clk = ~clk;

  vector_sequencer #(
    .N_IN(3), .HOLD_CYCLES(10), .EXPECTED(8'h31)
  ) dut (
    .clk(clk), .reset(reset), .start(start0), .y(y0), .vec(vec0), .busy(busy0),
    .done(done0), .pass(pass0), .err_count(err0), .first_fail_vec(ffv0),
    .first_fail_valid(ffvalid0)
  );

  vector_sequencer #(
    .N_IN(3), .HOLD_CYCLES(1), .EXPECTED(8'h31)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start1), .y(y1), .vec(vec1), .busy(busy1),
    .done(done1), .pass(pass1), .err_count(err1), .first_fail_vec(ffv1),
    .first_fail_valid(ffvalid1)
  );

  // mode 0: golden unit, 1: output stuck at 0, 2: golden with vec 3 inverted
  function automatic logic unit(input int m, input logic [2:0] v);
    logic a, b, c, g;
    a = v[2];
    b = v[1];
    c = v[0];
    g = (~a & ~b & ~c) | (a & ~b & ~c) | (a & ~b & c);
    case (m)
      1:       return 1'b0;
      2:       return g ^ (v == 3'd3);
      default: return g;
    endcase
  endfunction

  assign y0 = unit(mode, vec0);
  assign y1 = unit(mode, vec1);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run(input bit sel, input int h, input int m, input int ign_a, input int ign_b,
                     input int rst_at, input int exp_err, input int exp_ffv,
                     input int exp_ffvalid, input int exp_pass);
    int         total;
    logic [2:0] ov, of;
    logic [3:0] oe;
    logic       ob, od, op, ofv;
    total = 8 * h;
    mode  = m;
    @(negedge clk);
    if (sel) start1 = 1'b1;
    else start0 = 1'b1;
    for (int c = 1; c <= total + 2; c++) begin
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
      if (c == ign_a || c == ign_b) begin
        if (sel) start1 = 1'b1;
        else start0 = 1'b1;
      end
      ov  = sel ? vec1 : vec0;
      ob  = sel ? busy1 : busy0;
      od  = sel ? done1 : done0;
      op  = sel ? pass1 : pass0;
      oe  = sel ? err1 : err0;
      of  = sel ? ffv1 : ffv0;
      ofv = sel ? ffvalid1 : ffvalid0;
      if (c == 1) begin
        check($sformatf("clr_err h=%0d", h), 32'(oe), 0);
        check($sformatf("clr_ffvalid h=%0d", h), 32'(ofv), 0);
        check($sformatf("clr_ffv h=%0d", h), 32'(of), 0);
        check($sformatf("clr_pass h=%0d", h), 32'(op), 0);
      end
      if (rst_at > 0 && c > rst_at) begin
        reset = 1'b0;
        check($sformatf("rst_busy c=%0d", c), 32'(ob), 0);
        check($sformatf("rst_done c=%0d", c), 32'(od), 0);
        check($sformatf("rst_vec c=%0d", c), 32'(ov), 0);
        check($sformatf("rst_err c=%0d", c), 32'(oe), 0);
      end else if (c <= total) begin
        check($sformatf("vec h=%0d c=%0d", h, c), 32'(ov), (c - 1) / h);
        check($sformatf("busy h=%0d c=%0d", h, c), 32'(ob), 1);
        check($sformatf("done h=%0d c=%0d", h, c), 32'(od), 0);
      end else if (c == total + 1) begin
        check($sformatf("done_pulse h=%0d", h), 32'(od), 1);
        check($sformatf("done_busy h=%0d", h), 32'(ob), 0);
        check($sformatf("pass h=%0d m=%0d", h, m), 32'(op), exp_pass);
        check($sformatf("err h=%0d m=%0d", h, m), 32'(oe), exp_err);
        check($sformatf("ffv h=%0d m=%0d", h, m), 32'(of), exp_ffv);
        check($sformatf("ffvalid h=%0d m=%0d", h, m), 32'(ofv), exp_ffvalid);
      end else begin
        check($sformatf("post_done h=%0d", h), 32'(od), 0);
        check($sformatf("post_busy h=%0d", h), 32'(ob), 0);
        check($sformatf("hold_err h=%0d", h), 32'(oe), exp_err);
        check($sformatf("hold_pass h=%0d", h), 32'(op), exp_pass);
      end
      if (c == rst_at) reset = 1'b1;
    end
  endtask

  initial begin
    reset  = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    mode   = 0;
    repeat (3) @(negedge clk);
    // Start during reset must lose.
    start0 = 1'b1;
    @(negedge clk);
    check("rst_vec", 32'(vec0), 0);
    check("rst_busy", 32'(busy0), 0);
    check("rst_done", 32'(done0), 0);
    check("rst_pass", 32'(pass0), 0);
    check("rst_err", 32'(err0), 0);
    check("rst_ffv", 32'(ffv0), 0);
    check("rst_ffvalid", 32'(ffvalid0), 0);
    check("rst_busy1", 32'(busy1), 0);
    check("rst_vec1", 32'(vec1), 0);
    start0 = 1'b0;
    reset  = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy0), 0);

    run(1'b0, 10, 0, 0, 0, 0, 0, 0, 0, 1);
    run(1'b0, 10, 1, 0, 0, 0, 3, 0, 1, 0);
    run(1'b0, 10, 0, 20, 81, 0, 0, 0, 0, 1);
    run(1'b0, 10, 2, 0, 0, 0, 1, 3, 1, 0);
    run(1'b0, 10, 0, 0, 0, 55, 0, 0, 0, 0);
    run(1'b0, 10, 0, 0, 0, 0, 0, 0, 0, 1);
    run(1'b1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    run(1'b1, 1, 2, 0, 0, 0, 1, 3, 1, 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
